// File: rtl/bht_port_scheduler.sv
// bht_port_scheduler: owns the single port of the BHT counter SRAM.
// Runs the init/flush sweep, arbitrates frontend lookups against queued
// execute-stage updates, and performs each update as a read-modify-write
// of a 2-bit saturating counter.
// Optional feature macro: BHT_SCHED_STATS_EN enables the dropped-update
// counter on drop_cnt_o; without it drop_cnt_o is tied to zero.
//
// Handshake: lookup_valid_i is a level request; lookup_grant_o=1 means the
// read went to the SRAM this cycle and tbl_rdata_i carries the counter on
// the next cycle. A lookup that is not granted must be held (retried).
// upd_valid_i has no backpressure: an update that finds the FIFO full is
// dropped, and one that arrives during a sweep is discarded.
module bht_port_scheduler #(
  parameter int NR_ENTRIES     = 1024,
  parameter int IDX_W          = $clog2(NR_ENTRIES),
  parameter int UPD_FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_bp_i,
  input  logic             lookup_valid_i,
  input  logic [IDX_W-1:0] lookup_index_i,
  output logic             lookup_grant_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_index_i,
  input  logic             upd_taken_i,
  output logic             tbl_req_o,
  output logic             tbl_we_o,
  output logic [IDX_W-1:0] tbl_addr_o,
  output logic [1:0]       tbl_wdata_o,
  input  logic [1:0]       tbl_rdata_i,
  output logic             init_done_o,
  output logic [7:0]       drop_cnt_o,
  output logic [1:0]       dbg_state_o
);

  localparam int PTR_W = $clog2(UPD_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    UPD_RD = 2'd2,
    UPD_WR = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;

  logic [IDX_W-1:0] fifo_idx_q   [UPD_FIFO_DEPTH];
  logic             fifo_taken_q [UPD_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifo_full, fifo_empty, push, pop, fifo_clr;

  logic [IDX_W-1:0] hold_idx_q;
  logic             hold_taken_q;
  logic             upd_rd, upd_rd_q;
  logic [1:0]       rdata_q, rmw_old, rmw_new;

  assign fifo_full  = (count_q == CNT_W'(UPD_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // Occupancy is judged before any same-cycle pop, so a full FIFO drops.
  assign push = upd_valid_i && (state_q != INIT) && !fifo_full && !fifo_clr;

  // Full path reaches UPD_WR one cycle after the read, so the SRAM data is
  // live; the non-full path passes through UPD_RD, which captured it.
  assign rmw_old = upd_rd_q ? tbl_rdata_i : rdata_q;
  assign rmw_new = hold_taken_q ? ((rmw_old == 2'b11) ? 2'b11 : rmw_old + 2'b01)
                                : ((rmw_old == 2'b00) ? 2'b00 : rmw_old - 2'b01);

  assign init_done_o = (state_q != INIT);
  assign dbg_state_o = state_q;

  // Next-state, arbitration and SRAM port drive.
  always_comb begin
    state_d        = state_q;
    sweep_d        = sweep_q;
    pop            = 1'b0;
    fifo_clr       = 1'b0;
    upd_rd         = 1'b0;
    lookup_grant_o = 1'b0;
    tbl_req_o      = 1'b0;
    tbl_we_o       = 1'b0;
    tbl_addr_o     = sweep_q;
    tbl_wdata_o    = 2'b01;
    case (state_q)
      INIT: begin
        tbl_req_o   = 1'b1;
        tbl_we_o    = 1'b1;
        tbl_addr_o  = sweep_q;
        tbl_wdata_o = 2'b01;
        if (flush_bp_i) begin
          sweep_d  = '0;
          fifo_clr = 1'b1;
        end else if (sweep_q == LAST_IDX) begin
          sweep_d = '0;
          state_d = IDLE;
        end else begin
          sweep_d = sweep_q + IDX_W'(1);
        end
      end
      IDLE: begin
        if (flush_bp_i) begin
          state_d  = INIT;
          sweep_d  = '0;
          fifo_clr = 1'b1;
        end else if (fifo_full) begin
          tbl_req_o  = 1'b1;
          tbl_addr_o = fifo_idx_q[rd_ptr_q];
          pop        = 1'b1;
          upd_rd     = 1'b1;
          state_d    = UPD_WR;
        end else if (lookup_valid_i) begin
          lookup_grant_o = 1'b1;
          tbl_req_o      = 1'b1;
          tbl_addr_o     = lookup_index_i;
        end else if (!fifo_empty) begin
          tbl_req_o  = 1'b1;
          tbl_addr_o = fifo_idx_q[rd_ptr_q];
          pop        = 1'b1;
          upd_rd     = 1'b1;
          state_d    = UPD_RD;
        end
      end
      UPD_RD: begin
        if (flush_bp_i) begin
          state_d  = INIT;
          sweep_d  = '0;
          fifo_clr = 1'b1;
        end else begin
          state_d = UPD_WR;
        end
      end
      UPD_WR: begin
        if (flush_bp_i) begin
          state_d  = INIT;
          sweep_d  = '0;
          fifo_clr = 1'b1;
        end else begin
          tbl_req_o   = 1'b1;
          tbl_we_o    = 1'b1;
          tbl_addr_o  = hold_idx_q;
          tbl_wdata_o = rmw_new;
          state_d     = IDLE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // State, sweep pointer and RMW holding registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= INIT;
      sweep_q      <= '0;
      hold_idx_q   <= '0;
      hold_taken_q <= 1'b0;
      upd_rd_q     <= 1'b0;
      rdata_q      <= 2'b00;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      upd_rd_q <= upd_rd;
      if (upd_rd_q) rdata_q <= tbl_rdata_i;
      if (pop) begin
        hold_idx_q   <= fifo_idx_q[rd_ptr_q];
        hold_taken_q <= fifo_taken_q[rd_ptr_q];
      end
    end
  end

  // Update FIFO pointers and occupancy; flush empties it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (fifo_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Update FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q]   <= upd_index_i;
      fifo_taken_q[wr_ptr_q] <= upd_taken_i;
    end
  end

`ifdef BHT_SCHED_STATS_EN
  logic       drop;
  logic [7:0] drop_cnt_q;
  assign drop = upd_valid_i && (state_q != INIT) && fifo_full;

  // Saturating count of updates lost to a full FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= 8'd0;
    end else if (flush_bp_i) begin
      drop_cnt_q <= 8'd0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end
  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = 8'd0;
`endif

endmodule
